branch_hazard_unit: RTL and testbench

Hazard-detection and forwarding-control block for the decode stage of the Mini-RISC-V five-stage pipeline. It keeps a shadow pipeline of destination-register tags (ID/EX, EX/MEM, MEM/WB) and produces the match and qualifier flags consumed by `branchforward`. It also produces the stall, bubble and flush controls needed when a branch in ID depends on a result that forwarding cannot yet supply. It is the control-side producer for the ID-stage branch-operand forwarding mux.

---
 rtl/branch_hazard_unit.sv | 145 ++++++++++++++
 tb/tb_branch_hazard_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_unit.sv
// Decode-stage hazard unit: shadow rd pipeline, branch-operand match flags,
// and stall/bubble/flush control for branches waiting on in-flight results.
module branch_hazard_unit #(
  parameter int REGW     = 5,
  parameter int MAXSTALL = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_is_branch,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            branch_taken,
  output logic            zero3,
  output logic            zero4,
  output logic            zeroa,
  output logic            zerob,
  output logic            EX_MEM_regwrite,
  output logic            EX_MEM_memread,
  output logic            MEM_WB_regwrite,
  output logic            stall,
  output logic            bubble,
  output logic            flush_if,
  output logic [1:0]      stall_cnt
);

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  state_t          r_state, w_state_next;
  logic [1:0]      r_cnt, w_cnt_next;
  logic [REGW-1:0] r_idex_rd, r_exmem_rd, r_memwb_rd;
  logic            r_idex_rw, r_idex_mr, r_exmem_rw, r_exmem_mr, r_memwb_rw;
  logic [1:0]      w_need1, w_need2, w_need;

  // Stall cycles one source operand needs before forwarding can cover it.
  function automatic logic [1:0] f_need(
    input logic [REGW-1:0] s,
    input logic            use_s,
    input logic            valid,
    input logic            is_branch,
    input logic [REGW-1:0] idex_rd,
    input logic            idex_rw,
    input logic            idex_mr,
    input logic [REGW-1:0] exmem_rd,
    input logic            exmem_mr
  );
    logic [1:0] n;
    n = 2'd0;
    if (valid && use_s && (s != '0)) begin
      if (is_branch) begin
        if (idex_rw && (idex_rd == s))
          n = idex_mr ? 2'(MAXSTALL) : 2'd1;
        else if (exmem_mr && (exmem_rd == s))
          n = 2'd1;
      end else if (idex_mr && (idex_rd == s)) begin
        n = 2'd1;
      end
    end
    return n;
  endfunction

  assign w_need1 = f_need(id_rs1, id_use_rs1, id_valid, id_is_branch,
                          r_idex_rd, r_idex_rw, r_idex_mr, r_exmem_rd, r_exmem_mr);
  assign w_need2 = f_need(id_rs2, id_use_rs2, id_valid, id_is_branch,
                          r_idex_rd, r_idex_rw, r_idex_mr, r_exmem_rd, r_exmem_mr);
  assign w_need  = (w_need1 > w_need2) ? w_need1 : w_need2;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    stall        = 1'b0;
    stall_cnt    = 2'd0;
    case (r_state)
      ST_RUN: begin
        if (w_need != 2'd0) begin
          stall     = 1'b1;
          stall_cnt = w_need;
          if (w_need > 2'd1) begin
            w_state_next = ST_STALL;
            w_cnt_next   = w_need - 2'd1;
          end
        end
      end
      ST_STALL: begin
        stall      = 1'b1;
        stall_cnt  = r_cnt;
        w_cnt_next = r_cnt - 2'd1;
        if (r_cnt == 2'd1) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign bubble   = stall & ~freeze;
  assign flush_if = id_valid & id_is_branch & branch_taken & ~stall & ~freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else if (!freeze) begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A stalled cycle pushes a NOP into ID/EX while the ID instruction is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex_rd  <= '0;
      r_idex_rw  <= 1'b0;
      r_idex_mr  <= 1'b0;
      r_exmem_rd <= '0;
      r_exmem_rw <= 1'b0;
      r_exmem_mr <= 1'b0;
      r_memwb_rd <= '0;
      r_memwb_rw <= 1'b0;
    end else if (!freeze) begin
      r_idex_rd  <= id_rd;
      r_idex_rw  <= id_regwrite & id_valid & ~stall;
      r_idex_mr  <= id_memread & id_valid & ~stall;
      r_exmem_rd <= r_idex_rd;
      r_exmem_rw <= r_idex_rw;
      r_exmem_mr <= r_idex_mr;
      r_memwb_rd <= r_exmem_rd;
      r_memwb_rw <= r_exmem_rw;
    end
  end

  assign zero3 = id_use_rs1 & (r_exmem_rd != '0) & (r_exmem_rd == id_rs1);
  assign zero4 = id_use_rs2 & (r_exmem_rd != '0) & (r_exmem_rd == id_rs2);
  assign zeroa = id_use_rs1 & (r_memwb_rd != '0) & (r_memwb_rd == id_rs1);
  assign zerob = id_use_rs2 & (r_memwb_rd != '0) & (r_memwb_rd == id_rs2);

  assign EX_MEM_regwrite = r_exmem_rw;
  assign EX_MEM_memread  = r_exmem_mr;
  assign MEM_WB_regwrite = r_memwb_rw;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Scenario bench for branch_hazard_unit: per-cycle expected output vectors are
// queued as stimulus is driven and popped at the falling edge for comparison.
module tb_branch_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_is_branch, id_regwrite, id_memread;
  logic       branch_taken;
  logic       zero3, zero4, zeroa, zerob;
  logic       EX_MEM_regwrite, EX_MEM_memread, MEM_WB_regwrite;
  logic       stall, bubble, flush_if;
  logic [1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       tk;
    logic       frz;
  } stim_t;

  branch_hazard_unit #(.REGW(5), .MAXSTALL(2)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken(branch_taken),
    .zero3(zero3), .zero4(zero4), .zeroa(zeroa), .zerob(zerob),
    .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_memread(EX_MEM_memread),
    .MEM_WB_regwrite(MEM_WB_regwrite),
    .stall(stall), .bubble(bubble), .flush_if(flush_if), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {zero3, zero4, zeroa, zerob, EX_MEM_regwrite, EX_MEM_memread,
                MEM_WB_regwrite, stall, bubble, flush_if, stall_cnt};

  function automatic stim_t S(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic br,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic tk, input logic frz);
    stim_t s;
    s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.br = br;
    s.rd = rd; s.rw = rw; s.mr = mr; s.tk = tk; s.frz = frz;
    return s;
  endfunction

  // {z3,z4,za,zb,exmem_rw,exmem_mr,memwb_rw,stall,bubble,flush,cnt}
  function automatic logic [11:0] E(input logic z3, input logic z4, input logic za,
                                    input logic zb, input logic erw, input logic emr,
                                    input logic mrw, input logic st, input logic bb,
                                    input logic fl, input logic [1:0] cnt);
    return {z3, z4, za, zb, erw, emr, mrw, st, bb, fl, cnt};
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.v; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_is_branch = s.br;
    id_rd = s.rd; id_regwrite = s.rw; id_memread = s.mr;
    branch_taken = s.tk; freeze = s.frz;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset;
    logic [11:0] e;
    rst = 1'b1;
    drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(12'd0);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL reset: got %b expected %b", obs, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_alu_branch;
    stim_t t[4];
    logic [11:0] x[4];
    logic [11:0] e;
    t[0] = S(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0); x[0] = 12'd0;
    t[1] = S(1, 5, 0, 1, 0, 1, 0, 0, 0, 1, 0); x[1] = E(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd1);
    t[2] = t[1];                               x[2] = E(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'd0);
    t[3] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x[3] = E(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL alu_branch[%0d]: got %b expected %b", i, obs, e);
      end
    end
    idle(3);
  endtask

  task automatic test_load_branch;
    stim_t t[4];
    logic [11:0] x[4];
    logic [11:0] e;
    t[0] = S(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0); x[0] = 12'd0;
    t[1] = S(1, 1, 7, 0, 1, 1, 0, 0, 0, 1, 0); x[1] = E(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd2);
    t[2] = t[1];                               x[2] = E(0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 2'd1);
    t[3] = t[1];                               x[3] = E(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL load_branch[%0d]: got %b expected %b", i, obs, e);
      end
    end
    idle(3);
  endtask

  task automatic test_load_use;
    stim_t t[5];
    logic [11:0] x[5];
    logic [11:0] e;
    t[0] = S(1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0); x[0] = 12'd0;
    t[1] = S(1, 3, 4, 1, 1, 0, 8, 1, 0, 0, 0); x[1] = E(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd1);
    t[2] = t[1];                               x[2] = E(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0);
    t[3] = S(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); x[3] = E(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    t[4] = S(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0); x[4] = E(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, obs, e);
      end
    end
    idle(3);
  endtask

  task automatic test_taken;
    stim_t t[3];
    logic [11:0] x[3];
    logic [11:0] e;
    t[0] = S(1, 2, 0, 1, 0, 1, 0, 0, 0, 1, 0); x[0] = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0);
    t[1] = S(1, 2, 0, 1, 0, 1, 0, 0, 0, 1, 1); x[1] = 12'd0;
    t[2] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x[2] = 12'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL taken[%0d]: got %b expected %b", i, obs, e);
      end
    end
    idle(3);
  endtask

  task automatic test_freeze;
    stim_t t[7];
    logic [11:0] x[7];
    logic [11:0] e;
    int stall_cycles = 0;
    t[0] = S(1, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0); x[0] = 12'd0;
    t[1] = S(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0); x[1] = E(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd2);
    for (int i = 2; i < 5; i++) begin
      t[i] = S(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 1); x[i] = E(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 2'd1);
    end
    t[5] = t[1];                               x[5] = E(1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 2'd1);
    t[6] = t[1];                               x[6] = E(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      if (stall === 1'b1) stall_cycles++;
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL freeze[%0d]: got %b expected %b", i, obs, e);
      end
    end
    n_cmp++;
    if (stall_cycles != 5) begin
      n_bad++;
      $display("FAIL freeze_stall_len: got %0d expected 5", stall_cycles);
    end
    idle(3);
  endtask

  task automatic test_reset_mid_stall;
    stim_t t[3];
    logic [11:0] x[3];
    logic [11:0] e;
    t[0] = S(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0); x[0] = 12'd0;
    t[1] = S(1, 0, 7, 0, 1, 1, 0, 0, 0, 0, 0); x[1] = E(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd2);
    t[2] = t[1];                               x[2] = E(0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 2'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL rst_mid[%0d]: got %b expected %b", i, obs, e);
      end
    end
    #2 rst = 1'b1;
    exp_q.push_back(12'd0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL rst_mid_async: got %b expected %b", obs, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(12'd0);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL rst_mid_release: got %b expected %b", obs, e);
    end
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu_branch();
    test_load_branch();
    test_load_use();
    test_taken();
    test_freeze();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
